mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MEM stage of the SPARC pipeline. It consumes the EX/MEM register outputs: ALU result or address, store data, load/rf_le/rd, enable, size and read/write. It performs byte, halfword or word accesses to the data memory over a req/ack handshake, with big-endian lane steering and sign/zero extension. It stalls upstream stages while an access is outstanding, flags misaligned accesses and bus timeouts, and drives the MEM/WB register plus the MEM forwarding value used by the hazard unit.

Parameters:
TIMEOUT, 16, cycles in BUSY without dm_ack before the access is aborted with bus_err (range 2..255).

Ports:
clk  in  1  clock; all state changes on posedge.
R  in  1  reset; asynchronous, active-low.
mem_load  in  1  instruction is a load.
mem_rf_le  in  1  register-file write enable from EX/MEM.
mem_rd  in  5  destination register.
mem_E  in  1  data-memory access enable.
mem_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
mem_rw_dm  in  1  0 read, 1 write.
mem_se  in  1  sign-extend load data (1 signed, 0 zero-extend).
mem_alu_out  in  32  effective address or ALU result.
mem_df_a  in  32  store data.
dm_rdata  in  32  memory read data; valid when dm_ack=1.
dm_ack  in  1  memory completion strobe.
dm_req  out  1  request; high for the whole BUSY state.
dm_we  out  1  write strobe, qualified by dm_req.
dm_addr  out  32  {mem_alu_out[31:2],2'b00}.
dm_be  out  4  byte enables; bit3 = bits 31:24.
dm_wdata  out  32  lane-replicated store data.
stall_mem  out  1  freezes IF/ID/EX and EX/MEM.
mem_fwd_data  out  32  combinational forwarding value (mem_alu_out).
wb_rd  out  5  MEM/WB destination register.
wb_rf_le  out  1  MEM/WB write enable.
wb_data  out  32  MEM/WB write-back data.
misalign_trap  out  1  one-cycle registered pulse.
bus_err  out  1  one-cycle registered pulse.

Behaviour:
- Reset (R=0, async): state IDLE, timeout counter 0, wb_rd=0, wb_rf_le=0, wb_data=0, misalign_trap=0, bus_err=0. dm_req=0 and stall_mem=0 follow from IDLE. Reset mid-access drops dm_req immediately, and any later dm_ack is ignored.
- Definitions: access = mem_E. misaligned = access and (size 01 with addr[0]=1, or size 10 with addr[1:0]!=0, or size 11).
- States:
  - IDLE: the only state an instruction first enters.
  - BUSY: a request is outstanding.
- IDLE, no access: MEM/WB latches wb_data=mem_alu_out, wb_rd=mem_rd and wb_rf_le=mem_rf_le at the edge. Latency is 1 cycle and stall_mem=0.
- IDLE, misaligned access:
  - no request is issued and stall_mem=0;
  - at the edge, misalign_trap<=1, wb_rf_le<=0 and no write reaches memory.
- IDLE, aligned access: stall_mem=1 combinationally. At the edge the state goes to BUSY and the counter is cleared.
- BUSY:
  - dm_req=1 and dm_we=mem_rw_dm. Inputs are held stable by the stall.
  - stall_mem = ~dm_ack & (counter<TIMEOUT-1).
  - The counter increments each cycle without ack.
- BUSY with dm_ack: return to IDLE.
  - Load: wb_data<=formatted dm_rdata and wb_rf_le<=mem_rf_le.
  - Store: wb_rf_le<=0.
  - Minimum access latency is 2 cycles (ack in the first BUSY cycle).
- BUSY timeout (counter=TIMEOUT-1, no ack): return to IDLE with bus_err<=1 and wb_rf_le<=0. If dm_ack arrives in the same cycle, it wins and bus_err stays 0.
- Lane select, big-endian:
  - byte, addr[1:0]=00..11 -> dm_be 1000, 0100, 0010, 0001;
  - half, addr[1]=0 -> 1100, addr[1]=1 -> 0011;
  - word -> 1111.
- Store data: byte -> {4{df_a[7:0]}}, half -> {2{df_a[15:0]}}, word -> df_a.
- Load format: extract the selected lane, then sign-extend if mem_se else zero-extend. Word loads pass through unchanged.
- Trap and error pulses last exactly 1 cycle and clear on the following edge unless re-triggered.
- mem_fwd_data always equals mem_alu_out. Load data is not forwarded from MEM; the load-use stall upstream covers that case.

Test Plan:
- Pass-through: mem_E=0, alu_out=0x0000_1234, rd=5, rf_le=1 -> next edge wb_data=0x1234, wb_rd=5, wb_rf_le=1; stall_mem never asserts.
- Signed byte load: addr=0x103, size=00, se=1, ack in the first BUSY cycle with rdata=0x1122_3380 -> dm_be=0001, dm_addr=0x100, stall for exactly 1 cycle, wb_data=0xFFFF_FF80. Repeat with se=0 -> wb_data=0x0000_0080.
- Halfword store: addr=0x202, size=01, rw=1, df_a=0xDEAD_BEEF, ack after 3 cycles -> dm_we=1, dm_be=0011, dm_wdata=0xBEEF_BEEF, stall_mem high for 4 cycles, wb_rf_le=0.
- Misaligned word load: addr=0x301, size=10 -> dm_req never asserts, misalign_trap is a 1-cycle pulse, wb_rf_le=0, no stall.
- Timeout with TIMEOUT=4 and dm_ack held low: stall_mem high 4 cycles, then bus_err pulses and state returns to IDLE. Variant: ack on the final counter cycle -> bus_err=0 and data is written back.
- Reset mid-access: drive R=0 while in BUSY -> dm_req=0 and all wb_* outputs=0 immediately. After release, a stale dm_ack causes no write-back.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory access, lane steering, MEM/WB register
//
// Purpose:
//   Consumes the EX/MEM register, performs byte/halfword/word data-memory
//   accesses over a req/ack handshake with big-endian lane steering and
//   sign/zero extension of load data, stalls upstream while an access is
//   outstanding, flags misaligned accesses and bus timeouts, and drives the
//   MEM/WB register plus the MEM-stage forwarding value.
//
// Ports:
//   clk, R            clock (posedge) and asynchronous active-low reset
//   mem_*             EX/MEM register fields (load, rf_le, rd, E, size, rw_dm,
//                     se, alu_out, df_a)
//   dm_*              data-memory request/ack interface
//   stall_mem         freezes IF/ID/EX and EX/MEM while an access is pending
//   mem_fwd_data      forwarding value for the hazard unit (ALU result)
//   wb_rd/rf_le/data  MEM/WB register outputs
//   misalign_trap     one-cycle registered pulse on a misaligned access
//   bus_err           one-cycle registered pulse on a bus timeout

module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        R,
  input  logic        mem_load,
  input  logic        mem_rf_le,
  input  logic [4:0]  mem_rd,
  input  logic        mem_E,
  input  logic [1:0]  mem_size,
  input  logic        mem_rw_dm,
  input  logic        mem_se,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_df_a,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  output logic        stall_mem,
  output logic [31:0] mem_fwd_data,
  output logic [4:0]  wb_rd,
  output logic        wb_rf_le,
  output logic [31:0] wb_data,
  output logic        misalign_trap,
  output logic        bus_err
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rf_le_q, wb_rf_le_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        trap_q, trap_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic        timeout_hit;
  logic [31:0] load_data;

  wire [1:0] a_lo = mem_alu_out[1:0];

  // Reserved size 11 is always treated as misaligned so it never reaches memory.
  always_comb begin
    misaligned = 1'b0;
    if (mem_E) begin
      unique case (mem_size)
        SZ_BYTE: misaligned = 1'b0;
        SZ_HALF: misaligned = a_lo[0];
        SZ_WORD: misaligned = (a_lo != 2'b00);
        default: misaligned = 1'b1;
      endcase
    end
  end

  // Big-endian lanes: address offset 0 maps to bits 31:24.
  always_comb begin
    dm_be    = 4'b0000;
    dm_wdata = mem_df_a;
    unique case (mem_size)
      SZ_BYTE: begin
        dm_be    = 4'b1000 >> a_lo;
        dm_wdata = {4{mem_df_a[7:0]}};
      end
      SZ_HALF: begin
        dm_be    = a_lo[1] ? 4'b0011 : 4'b1100;
        dm_wdata = {2{mem_df_a[15:0]}};
      end
      SZ_WORD: begin
        dm_be    = 4'b1111;
        dm_wdata = mem_df_a;
      end
      default: begin
        dm_be    = 4'b0000;
        dm_wdata = mem_df_a;
      end
    endcase
  end

  // Lane extraction and extension of returned read data.
  always_comb begin
    logic [7:0]  rb;
    logic [15:0] rh;
    rb = 8'h00;
    rh = 16'h0000;
    unique case (a_lo)
      2'b00:   rb = dm_rdata[31:24];
      2'b01:   rb = dm_rdata[23:16];
      2'b10:   rb = dm_rdata[15:8];
      default: rb = dm_rdata[7:0];
    endcase
    rh = a_lo[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    unique case (mem_size)
      SZ_BYTE: load_data = {{24{mem_se & rb[7]}}, rb};
      SZ_HALF: load_data = {{16{mem_se & rh[15]}}, rh};
      default: load_data = dm_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_rd_d    = wb_rd_q;
    wb_rf_le_d = wb_rf_le_q;
    wb_data_d  = wb_data_q;
    trap_d     = 1'b0;
    err_d      = 1'b0;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    stall_mem  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!mem_E) begin
          wb_data_d  = mem_alu_out;
          wb_rd_d    = mem_rd;
          wb_rf_le_d = mem_rf_le;
        end else if (misaligned) begin
          trap_d     = 1'b1;
          wb_data_d  = mem_alu_out;
          wb_rd_d    = mem_rd;
          wb_rf_le_d = 1'b0;
        end else begin
          // Bubble into WB while the access is in flight so the previous
          // instruction is not written back twice.
          stall_mem  = 1'b1;
          state_d    = ST_BUSY;
          cnt_d      = 8'd0;
          wb_rf_le_d = 1'b0;
        end
      end
      ST_BUSY: begin
        dm_req    = 1'b1;
        dm_we     = mem_rw_dm;
        stall_mem = ~dm_ack & (cnt_q < CNT_LAST);
        if (dm_ack) begin
          // Ack wins over a simultaneous timeout.
          state_d = ST_IDLE;
          wb_rd_d = mem_rd;
          if (mem_rw_dm) begin
            wb_rf_le_d = 1'b0;
          end else begin
            wb_rf_le_d = mem_rf_le;
            wb_data_d  = mem_load ? load_data : mem_alu_out;
          end
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          err_d      = 1'b1;
          wb_rf_le_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      wb_rd_q    <= 5'd0;
      wb_rf_le_q <= 1'b0;
      wb_data_q  <= 32'd0;
      trap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_rd_q    <= wb_rd_d;
      wb_rf_le_q <= wb_rf_le_d;
      wb_data_q  <= wb_data_d;
      trap_q     <= trap_d;
      err_q      <= err_d;
    end
  end

  assign dm_addr       = {mem_alu_out[31:2], 2'b00};
  assign mem_fwd_data  = mem_alu_out;
  assign wb_rd         = wb_rd_q;
  assign wb_rf_le      = wb_rf_le_q;
  assign wb_data       = wb_data_q;
  assign misalign_trap = trap_q;
  assign bus_err       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_rf_le = 1'b0;
  logic [4:0]  mem_rd = 5'd0;
  logic        mem_E = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_rw_dm = 1'b0;
  logic        mem_se = 1'b0;
  logic [31:0] mem_alu_out = 32'd0;
  logic [31:0] mem_df_a = 32'd0;
  logic [31:0] dm_rdata = 32'd0;
  logic        dm_ack = 1'b0;
  logic        dm_req, dm_we, stall_mem, wb_rf_le, misalign_trap, bus_err;
  logic [31:0] dm_addr, dm_wdata, mem_fwd_data, wb_data;
  logic [3:0]  dm_be;
  logic [4:0]  wb_rd;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .R(R),
    .mem_load(mem_load), .mem_rf_le(mem_rf_le), .mem_rd(mem_rd),
    .mem_E(mem_E), .mem_size(mem_size), .mem_rw_dm(mem_rw_dm),
    .mem_se(mem_se), .mem_alu_out(mem_alu_out), .mem_df_a(mem_df_a),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .stall_mem(stall_mem), .mem_fwd_data(mem_fwd_data),
    .wb_rd(wb_rd), .wb_rf_le(wb_rf_le), .wb_data(wb_data),
    .misalign_trap(misalign_trap), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one instruction at posedge+1 and runs it until the stage stops stalling.
  // ack_at: BUSY cycle index in which dm_ack is driven (-1 = never).
  task automatic do_access(input logic [31:0] addr, input logic [1:0] size, input logic rw,
                           input logic se, input logic [31:0] df, input logic [31:0] rdata,
                           input int ack_at,
                           output int stalls, output logic saw_req, output logic [3:0] be,
                           output logic [31:0] wdata, output logic we, output logic [31:0] addr_o,
                           output logic trap, output logic err);
    int  busy_n;
    logic st;
    logic done;
    busy_n = 0; stalls = 0; saw_req = 1'b0; be = 4'h0; wdata = 32'h0; we = 1'b0;
    addr_o = 32'h0; done = 1'b0;
    mem_E = 1'b1; mem_alu_out = addr; mem_size = size; mem_rw_dm = rw; mem_se = se;
    mem_df_a = df; mem_load = ~rw; mem_rf_le = 1'b1; mem_rd = 5'd7; dm_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      if (dm_req) begin
        saw_req = 1'b1; we = dm_we; be = dm_be; wdata = dm_wdata; addr_o = dm_addr;
        dm_ack = (busy_n == ack_at);
        busy_n++;
      end else begin
        dm_ack = 1'b0;
      end
      #1;
      st = stall_mem;
      if (st) stalls++;
      @(posedge clk); #1;
      if (!st) begin
        done = 1'b1;
        break;
      end
    end
    check("access_completes", {31'd0, done}, 32'd1);
    mem_E = 1'b0; dm_ack = 1'b0; mem_rf_le = 1'b0;
    trap = misalign_trap;
    err = bus_err;
  endtask

  int          stalls;
  logic        saw_req, we, trap, err;
  logic [3:0]  be;
  logic [31:0] wdata, addr_o;

  initial begin
    #12;
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    check("rst_dm_req", {31'd0, dm_req}, 32'd0);
    check("rst_stall", {31'd0, stall_mem}, 32'd0);
    check("rst_trap_err", {30'd0, misalign_trap, bus_err}, 32'd0);
    @(negedge clk); R = 1'b1;
    @(posedge clk); #1;

    // Pass-through
    mem_E = 1'b0; mem_alu_out = 32'h0000_1234; mem_rd = 5'd5; mem_rf_le = 1'b1;
    #1;
    check("pt_stall", {31'd0, stall_mem}, 32'd0);
    check("pt_fwd", mem_fwd_data, 32'h0000_1234);
    @(posedge clk); #1;
    check("pt_wb_data", wb_data, 32'h0000_1234);
    check("pt_wb_rd", {27'd0, wb_rd}, 32'd5);
    check("pt_wb_rf_le", {31'd0, wb_rf_le}, 32'd1);

    // Signed byte load, ack in first BUSY cycle
    do_access(32'h103, 2'b00, 1'b0, 1'b1, 32'h0, 32'h1122_3380, 0,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("lbs_stalls", stalls, 32'd1);
    check("lbs_be", {28'd0, be}, 32'h1);
    check("lbs_addr", addr_o, 32'h100);
    check("lbs_we", {31'd0, we}, 32'd0);
    check("lbs_wb_data", wb_data, 32'hFFFF_FF80);
    check("lbs_wb_rf_le", {31'd0, wb_rf_le}, 32'd1);
    check("lbs_wb_rd", {27'd0, wb_rd}, 32'd7);

    // Unsigned byte load
    do_access(32'h103, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1122_3380, 0,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("lbu_wb_data", wb_data, 32'h0000_0080);

    // Halfword store, ack in 4th BUSY cycle
    do_access(32'h202, 2'b01, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 3,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("sh_stalls", stalls, 32'd4);
    check("sh_we", {31'd0, we}, 32'd1);
    check("sh_be", {28'd0, be}, 32'h3);
    check("sh_wdata", wdata, 32'hBEEF_BEEF);
    check("sh_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    check("sh_err", {31'd0, err}, 32'd0);

    // Halfword signed load, ack on the final counter cycle: ack wins
    do_access(32'h200, 2'b01, 1'b0, 1'b1, 32'h0, 32'h8001_0000, 3,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("lhlate_be", {28'd0, be}, 32'hC);
    check("lhlate_err", {31'd0, err}, 32'd0);
    check("lhlate_wb_data", wb_data, 32'hFFFF_8001);
    check("lhlate_wb_rf_le", {31'd0, wb_rf_le}, 32'd1);

    // Word load, ack in 2nd BUSY cycle
    do_access(32'h400, 2'b10, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 1,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("lw_stalls", stalls, 32'd2);
    check("lw_be", {28'd0, be}, 32'hF);
    check("lw_wb_data", wb_data, 32'hCAFE_F00D);

    // Byte store at offset 1
    do_access(32'h401, 2'b00, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 0,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("sb_be", {28'd0, be}, 32'h4);
    check("sb_wdata", wdata, 32'h7878_7878);

    // Misaligned word load
    do_access(32'h301, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 0,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("mis_stalls", stalls, 32'd0);
    check("mis_req", {31'd0, saw_req}, 32'd0);
    check("mis_trap", {31'd0, trap}, 32'd1);
    check("mis_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    @(posedge clk); #1;
    check("mis_trap_clear", {31'd0, misalign_trap}, 32'd0);

    // Timeout, ack never arrives
    do_access(32'h500, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, -1,
              stalls, saw_req, be, wdata, we, addr_o, trap, err);
    check("to_stalls", stalls, 32'd4);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    check("to_idle_req", {31'd0, dm_req}, 32'd0);
    @(posedge clk); #1;
    check("to_err_clear", {31'd0, bus_err}, 32'd0);

    // Reset mid-access
    mem_E = 1'b1; mem_alu_out = 32'h600; mem_size = 2'b10; mem_rw_dm = 1'b0;
    mem_load = 1'b1; mem_rf_le = 1'b1; mem_rd = 5'd9;
    @(posedge clk); #1;
    check("rma_busy_req", {31'd0, dm_req}, 32'd1);
    R = 1'b0;
    #1;
    check("rma_req", {31'd0, dm_req}, 32'd0);
    check("rma_wb_data", wb_data, 32'd0);
    check("rma_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rma_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    mem_E = 1'b0; mem_rf_le = 1'b0; mem_alu_out = 32'd0; mem_rd = 5'd0;
    @(negedge clk); R = 1'b1;
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check("stale_wb_data", wb_data, 32'd0);
    check("stale_wb_rf_le", {31'd0, wb_rf_le}, 32'd0);
    check("stale_req", {31'd0, dm_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
